enc8b10b_lanes: RTL and testbench

Registered, parametrised 8b/10b line encoder for the IEEE1149.10 transmit path. It sits between the packet framer and the serialiser. It encodes NUM_LANES bytes per cycle into 10-bit symbols, tracks running disparity (RD) across lanes and cycles, and flags illegal control characters. It uses a valid/ready handshake, holds one output register stage, and can optionally fill idle cycles with K28.5 commas.

---
 rtl/enc8b10b_pkg.sv | 54 +++++
 rtl/enc8b10b_lanes_if.sv | 28 ++
 rtl/enc8b10b_lane.sv | 49 ++++
 rtl/enc8b10b_lanes.sv | 90 +++++++++
 tb/tb_enc8b10b_lanes.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b code tables and constants.
// The 5b/6b and 3b/4b tables hold the RD- form of each sub-block. The RD+
// form is the bitwise complement for unbalanced sub-blocks. It is also the
// complement for the balanced pairs D.07 (6b), D.x.3 (4b data) and every
// K.x.y 4b code.
package enc8b10b_pkg;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [7:0] K28_5  = 8'hBC;
    localparam logic [5:0] K28_6B = 6'b001111;
    localparam logic [3:0] A7_4B  = 4'b0111;

    // abcdei for x = 0..31, RD- form
    localparam logic [5:0] TBL_5B6B [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    // fghj for data y = 0..7, RD- form (index 7 is P7)
    localparam logic [3:0] TBL_3B4B_D [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    // fghj for control y = 0..7, RD- form (index 7 is A7)
    localparam logic [3:0] TBL_3B4B_K [8] = '{
        4'b1011, 4'b0110, 4'b1010, 4'b1100,
        4'b1101, 4'b0101, 4'b1001, 4'b0111
    };

    localparam int NUM_LEGAL_K = 12;
    localparam logic [7:0] LEGAL_K [NUM_LEGAL_K] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_legal_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL_K; i++) begin
            if (LEGAL_K[i] == b) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/enc8b10b_lanes_if.sv
// Handshake and data bundle for enc8b10b_lanes.
// slave : encoder side (takes input words, drives encoded words)
// master: framer/serialiser side (drives input words, takes encoded words)
interface enc8b10b_lanes_if #(
    parameter int NUM_LANES = 1
);
    logic                    in_valid;
    logic                    in_ready;
    logic [8*NUM_LANES-1:0]  in_data;
    logic [NUM_LANES-1:0]    in_k;
    logic                    rd_force;
    logic                    rd_value;
    logic                    out_valid;
    logic                    out_ready;
    logic [10*NUM_LANES-1:0] out_data;
    logic [NUM_LANES-1:0]    out_k_err;
    logic                    rd_out;

    modport slave (
        input  in_valid, in_data, in_k, rd_force, rd_value, out_ready,
        output in_ready, out_valid, out_data, out_k_err, rd_out
    );

    modport master (
        output in_valid, in_data, in_k, rd_force, rd_value, out_ready,
        input  in_ready, out_valid, out_data, out_k_err, rd_out
    );
endinterface

// File: rtl/enc8b10b_lane.sv
// Combinational single-lane 8b/10b encoder.
// data_i  : byte {HGF,EDCBA}
// k_i     : control-character request
// rd_i    : starting running disparity (0 = RD-)
// code_o  : {abcdei,fghj}, a at the MSB
// rd_o    : running disparity after this symbol
// k_err_o : k_i was set for a byte that is not a legal K code
module enc8b10b_lane
    import enc8b10b_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       k_i,
    input  logic       rd_i,
    output logic [9:0] code_o,
    output logic       rd_o,
    output logic       k_err_o
);
    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic [5:0] six_raw;
    logic [5:0] six;
    logic [3:0] four_raw;
    logic [3:0] four;
    logic       six_bal;
    logic       four_bal;
    logic       rd_mid;
    logic       use_a7;

    always_comb begin
        x        = data_i[4:0];
        y        = data_i[7:5];
        k_ok     = k_i && is_legal_k(data_i);
        six_raw  = (k_ok && (x == 5'd28)) ? K28_6B : TBL_5B6B[x];
        six_bal  = ($countones(six_raw) == 3);
        six      = (rd_i && (!six_bal || (x == 5'd7))) ? ~six_raw : six_raw;
        rd_mid   = six_bal ? rd_i : ~rd_i;
        // A7 avoids a run of five equal bits across the 6b/4b boundary
        use_a7   = (y == 3'd7) &&
                   ((!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                    ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        four_raw = k_ok ? TBL_3B4B_K[y] : (use_a7 ? A7_4B : TBL_3B4B_D[y]);
        four_bal = ($countones(four_raw) == 2);
        four     = (rd_mid && (k_ok || !four_bal || (y == 3'd3))) ? ~four_raw : four_raw;
        code_o   = {six, four};
        rd_o     = four_bal ? rd_mid : ~rd_mid;
        k_err_o  = k_i && !k_ok;
    end
endmodule

// File: rtl/enc8b10b_lanes.sv
// Registered multi-lane 8b/10b encoder with valid/ready handshake.
// clk       : rising-edge clock
// rst_n     : asynchronous active-low reset
// bus.slave : in_valid/in_ready/in_data/in_k input word, rd_force/rd_value
//             RD override, out_valid/out_ready/out_data/out_k_err output
//             word, rd_out current running disparity
// RD ripples lane 0 -> lane NUM_LANES-1 inside one word, and the last lane's
// ending RD is stored for the next word.
module enc8b10b_lanes
    import enc8b10b_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int IDLE_FILL = 0
) (
    input logic             clk,
    input logic             rst_n,
    enc8b10b_lanes_if.slave bus
);
    logic                    out_valid_q, out_valid_d;
    logic [10*NUM_LANES-1:0] out_data_q,  out_data_d;
    logic [NUM_LANES-1:0]    out_k_err_q, out_k_err_d;
    logic                    rd_q,        rd_d;

    logic                    in_ready;
    logic                    accept;
    logic                    idle_load;
    logic                    load;
    logic [8*NUM_LANES-1:0]  enc_data;
    logic [NUM_LANES-1:0]    enc_k;
    logic [NUM_LANES:0]      rd_chain;
    logic [10*NUM_LANES-1:0] enc_code;
    logic [NUM_LANES-1:0]    enc_k_err;

    assign in_ready  = !out_valid_q || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign idle_load = (IDLE_FILL != 0) && in_ready && !bus.in_valid;
    assign load      = accept || idle_load;

    // Idle words are K28.5 on every lane
    assign enc_data    = accept ? bus.in_data : {NUM_LANES{K28_5}};
    assign enc_k       = accept ? bus.in_k : {NUM_LANES{1'b1}};
    assign rd_chain[0] = bus.rd_force ? bus.rd_value : rd_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        enc8b10b_lane u_lane (
            .data_i  (enc_data[8*i +: 8]),
            .k_i     (enc_k[i]),
            .rd_i    (rd_chain[i]),
            .code_o  (enc_code[10*i +: 10]),
            .rd_o    (rd_chain[i+1]),
            .k_err_o (enc_k_err[i])
        );
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_k_err_d = out_k_err_q;
        rd_d        = rd_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = enc_code;
            out_k_err_d = enc_k_err;
            rd_d        = rd_chain[NUM_LANES];
        end else begin
            if (bus.out_ready) out_valid_d = 1'b0;
            if (bus.rd_force)  rd_d        = bus.rd_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_k_err_q <= '0;
            rd_q        <= RD_NEG;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_k_err_q <= out_k_err_d;
            rd_q        <= rd_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_k_err = out_k_err_q;
    assign bus.rd_out    = rd_q;
endmodule

// File: tb/tb_enc8b10b_lanes.sv
module tb_enc8b10b_lanes;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    enc8b10b_lanes_if #(.NUM_LANES(1)) if1 ();
    enc8b10b_lanes_if #(.NUM_LANES(2)) if2 ();
    enc8b10b_lanes_if #(.NUM_LANES(1)) if3 ();

    enc8b10b_lanes #(.NUM_LANES(1), .IDLE_FILL(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    enc8b10b_lanes #(.NUM_LANES(2), .IDLE_FILL(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    enc8b10b_lanes #(.NUM_LANES(1), .IDLE_FILL(1)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    // Reference code tables (RD- forms of the standard 8b/10b code)
    localparam logic [5:0] M6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [3:0] M4D [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] M4K [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                          8'hF7, 8'hFB, 8'hFD, 8'hFE};

    // One symbol. The RD after the symbol comes from the disparity of the
    // whole 10-bit symbol: balanced keeps RD, otherwise RD takes its sign.
    function automatic void model_sym(input logic [7:0] b, input logic k, input logic rd,
                                      output logic [9:0] sym, output logic rd_n, output logic kerr);
        int x;
        int y;
        logic legal;
        logic [5:0] s6;
        logic [3:0] s4;
        logic rd6;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        legal = k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        kerr = k && !legal;
        s6 = (legal && x == 28) ? 6'b001111 : M6[x];
        if (rd && ($countones(s6) != 3 || x == 7)) s6 = ~s6;
        rd6 = ($countones(s6) == 3) ? rd : ($countones(s6) > 3);
        if (legal) s4 = M4K[y];
        else if (y == 7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) ||
                            (rd6 && (x == 11 || x == 13 || x == 14)))) s4 = 4'b0111;
        else s4 = M4D[y];
        if (rd6 && (legal || $countones(s4) != 2 || y == 3)) s4 = ~s4;
        sym = {s6, s4};
        rd_n = ($countones(sym) == 5) ? rd : ($countones(sym) > 5);
    endfunction

    function automatic void model_word2(input logic [15:0] d, input logic [1:0] k, input logic rd0,
                                        output logic [19:0] code, output logic [1:0] kerr,
                                        output logic rd_end);
        logic r;
        logic [9:0] s;
        logic ke;
        r = rd0;
        code = '0;
        kerr = '0;
        for (int i = 0; i < 2; i++) begin
            model_sym(d[8*i +: 8], k[i], r, s, r, ke);
            code[10*i +: 10] = s;
            kerr[i] = ke;
        end
        rd_end = r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       k;
        logic       frc;
        logic       frc_val;
        logic [9:0] code;
        logic       kerr;
        logic       rd;
    } vec_t;

    vec_t vecs [14];

    logic        m_valid;
    logic [19:0] m_data;
    logic [1:0]  m_kerr;
    logic        m_rd;
    logic [19:0] w_code;
    logic [1:0]  w_kerr;
    logic        w_rd;
    logic        exp_rdy;

    initial begin
        checks = 0;
        failures = 0;
        vecs[0]  = '{8'hBC, 1'b1, 1'b0, 1'b0, 10'b0011111010, 1'b0, 1'b1};
        vecs[1]  = '{8'hBC, 1'b1, 1'b0, 1'b0, 10'b1100000101, 1'b0, 1'b0};
        vecs[2]  = '{8'hB5, 1'b0, 1'b0, 1'b0, 10'b1010101010, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'b1001110100, 1'b0, 1'b0};
        vecs[4]  = '{8'h00, 1'b1, 1'b0, 1'b0, 10'b1001110100, 1'b1, 1'b0};
        vecs[5]  = '{8'hF7, 1'b1, 1'b1, 1'b1, 10'b0001010111, 1'b0, 1'b1};
        vecs[6]  = '{8'hF1, 1'b0, 1'b0, 1'b0, 10'b1000110001, 1'b0, 1'b0};
        vecs[7]  = '{8'hF1, 1'b0, 1'b0, 1'b0, 10'b1000110111, 1'b0, 1'b1};
        vecs[8]  = '{8'hEB, 1'b0, 1'b0, 1'b0, 10'b1101001000, 1'b0, 1'b0};
        vecs[9]  = '{8'h67, 1'b0, 1'b0, 1'b0, 10'b1110001100, 1'b0, 1'b0};
        vecs[10] = '{8'h67, 1'b0, 1'b1, 1'b1, 10'b0001110011, 1'b0, 1'b1};
        vecs[11] = '{8'hFC, 1'b1, 1'b0, 1'b0, 10'b1100000111, 1'b0, 1'b1};
        vecs[12] = '{8'hFE, 1'b1, 1'b1, 1'b0, 10'b0111101000, 1'b0, 1'b0};
        vecs[13] = '{8'hDD, 1'b1, 1'b0, 1'b0, 10'b1011100110, 1'b1, 1'b1};

        rst_n = 1'b0;
        if1.in_valid = 0; if1.in_data = '0; if1.in_k = '0; if1.rd_force = 0; if1.rd_value = 0; if1.out_ready = 1;
        if2.in_valid = 0; if2.in_data = '0; if2.in_k = '0; if2.rd_force = 0; if2.rd_value = 0; if2.out_ready = 1;
        if3.in_valid = 0; if3.in_data = '0; if3.in_k = '0; if3.rd_force = 0; if3.rd_value = 0; if3.out_ready = 1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
        chk("rst_out_data",  32'(if1.out_data),  32'd0);
        chk("rst_k_err",     32'(if1.out_k_err), 32'd0);
        chk("rst_rd_out",    32'(if1.rd_out),    32'd0);
        chk("rst_idle_valid", 32'(if3.out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(if1.in_ready), 32'd1);

        // Idle fill: alternating K28.5, then a forced RD+
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("idle_valid", 32'(if3.out_valid), 32'd1);
            chk("idle_sym", 32'(if3.out_data), (i % 2 == 0) ? 32'b0011111010 : 32'b1100000101);
        end
        if3.rd_force = 1'b1;
        if3.rd_value = 1'b1;
        @(negedge clk);
        if3.rd_force = 1'b0;
        if3.rd_value = 1'b0;
        #1;
        chk("idle_force_sym", 32'(if3.out_data), 32'b1100000101);
        chk("idle_force_rd",  32'(if3.rd_out),   32'd0);

        // Single-lane vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if1.in_valid = 1'b1;
            if1.in_data  = vecs[i].data;
            if1.in_k     = vecs[i].k;
            if1.rd_force = vecs[i].frc;
            if1.rd_value = vecs[i].frc_val;
            @(negedge clk);
            if1.in_valid = 1'b0;
            if1.rd_force = 1'b0;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(if1.out_valid), 32'd1);
            chk($sformatf("vec%0d_code", i),  32'(if1.out_data),  32'(vecs[i].code));
            chk($sformatf("vec%0d_kerr", i),  32'(if1.out_k_err), 32'(vecs[i].kerr));
            chk($sformatf("vec%0d_rd", i),    32'(if1.rd_out),    32'(vecs[i].rd));
        end

        // Backpressure: A = D21.5, B = D10.2 (both RD-independent)
        @(negedge clk);
        if1.in_valid = 1'b1; if1.in_data = 8'hB5; if1.in_k = 1'b0; if1.out_ready = 1'b0;
        @(negedge clk);
        if1.in_data = 8'h4A;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid",    32'(if1.out_valid), 32'd1);
            chk("bp_in_ready", 32'(if1.in_ready),  32'd0);
            chk("bp_hold",     32'(if1.out_data),  32'b1010101010);
            @(negedge clk);
        end
        if1.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(if1.in_ready), 32'd1);
        chk("bp_release_a",   32'(if1.out_data), 32'b1010101010);
        @(negedge clk);
        if1.in_valid = 1'b0;
        #1;
        chk("bp_b_valid", 32'(if1.out_valid), 32'd1);
        chk("bp_b_data",  32'(if1.out_data),  32'b0101010101);
        @(negedge clk);
        #1;
        chk("bp_drained", 32'(if1.out_valid), 32'd0);

        // Two lanes, RD chaining within a word
        @(negedge clk);
        if2.in_valid = 1'b1; if2.in_data = 16'hBCBC; if2.in_k = 2'b11;
        @(negedge clk);
        if2.in_valid = 1'b0;
        #1;
        chk("l2_lane0", 32'(if2.out_data[9:0]),   32'b0011111010);
        chk("l2_lane1", 32'(if2.out_data[19:10]), 32'b1100000101);
        chk("l2_rd",    32'(if2.rd_out),          32'd0);

        // Randomised two-lane traffic against the reference model
        m_valid = 1'b0;
        m_data  = '0;
        m_kerr  = '0;
        m_rd    = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if2.in_valid  = ($urandom_range(3) != 0);
            if2.out_ready = ($urandom_range(2) != 0);
            for (int l = 0; l < 2; l++) begin
                if2.in_k[l] = ($urandom_range(3) == 0);
                if (if2.in_k[l] && $urandom_range(1) == 1)
                    if2.in_data[8*l +: 8] = KLIST[$urandom_range(11)];
                else
                    if2.in_data[8*l +: 8] = 8'($urandom);
            end
            exp_rdy = !m_valid || if2.out_ready;
            if2.rd_force = if2.in_valid && exp_rdy && ($urandom_range(7) == 0);
            if2.rd_value = 1'($urandom);
            #1;
            chk("rnd_in_ready",  32'(if2.in_ready),  32'(exp_rdy));
            chk("rnd_out_valid", 32'(if2.out_valid), 32'(m_valid));
            chk("rnd_rd",        32'(if2.rd_out),    32'(m_rd));
            if (m_valid) begin
                chk("rnd_data", 32'(if2.out_data),  32'(m_data));
                chk("rnd_kerr", 32'(if2.out_k_err), 32'(m_kerr));
            end
            if (if2.in_valid && exp_rdy) begin
                model_word2(if2.in_data, if2.in_k, if2.rd_force ? if2.rd_value : m_rd,
                            w_code, w_kerr, w_rd);
                m_valid = 1'b1;
                m_data  = w_code;
                m_kerr  = w_kerr;
                m_rd    = w_rd;
            end else if (if2.out_ready) begin
                m_valid = 1'b0;
            end
        end
        if2.in_valid = 1'b0;
        if2.rd_force = 1'b0;

        // Reset while a word is held discards it
        @(negedge clk);
        if1.in_valid = 1'b1; if1.in_data = 8'hBC; if1.in_k = 1'b1; if1.out_ready = 1'b0;
        @(negedge clk);
        if1.in_valid = 1'b0;
        #1;
        chk("mid_held_valid", 32'(if1.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(if1.out_valid), 32'd0);
        chk("mid_rst_data",  32'(if1.out_data),  32'd0);
        chk("mid_rst_rd",    32'(if1.rd_out),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
